ppu_fb_writer: RTL and testbench

//  Downstream of the PPU pixel mixer: consumes the 2-bit pixel stream (PX_OUT/PX_valid), maps it through BGP to a shade,
//  and writes it into a double-buffered 160x144 framebuffer RAM for the video output stage. Tracks column/row,

---
 rtl/ppu_fb_writer.sv | 182 ++++++++++++++++++
 tb/tb_ppu_fb_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_fb_writer.sv
`default_nettype none
// =============================================================================
// Module      : ppu_fb_writer
// Description : Maps the PPU pixel stream through BGP and writes the shades
//               into a double-buffered 160x144 framebuffer.
// Revision    : 1.0 - initial release
// =============================================================================
module ppu_fb_writer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 144,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LCD_EN,
  input  logic [1:0]        PPU_MODE,
  input  logic [7:0]        LY,
  input  logic [7:0]        BGP,
  input  logic [1:0]        PX_OUT,
  input  logic              PX_valid,
  output logic              FB_WE,
  output logic              FB_BANK,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [1:0]        FB_DATA,
  output logic              DISP_BANK,
  output logic              FRAME_DONE
);

  localparam logic [1:0] c_MODE_DRAW = 2'd3;

  localparam logic [1:0] c_FB_IDLE     = 2'd0;
  localparam logic [1:0] c_FB_DRAW     = 2'd1;
  localparam logic [1:0] c_FB_PAD      = 2'd2;
  localparam logic [1:0] c_FB_LINE_END = 2'd3;

  localparam logic [7:0]        c_H_RES    = 8'(H_RES);
  localparam logic [7:0]        c_V_RES    = 8'(V_RES);
  localparam logic [7:0]        c_LAST_ROW = 8'(V_RES - 1);
  localparam logic [ADDR_W-1:0] c_H_RES_A  = ADDR_W'(H_RES);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [7:0]        r_col;
  logic [7:0]        r_row;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_data;
  logic              r_bank;
  logic              r_frame_done;

  logic              w_mode_draw;
  logic              w_ly_visible;
  logic              w_col_full;
  logic [7:0]        w_col_inc;
  logic [7:0]        w_col_after;
  logic              w_accept;
  logic              w_pad_step;
  logic              w_start;
  logic              w_swap;
  logic              w_wr_en;
  logic [1:0]        w_px_shade;
  logic [1:0]        w_wr_data;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_mode_draw  = (PPU_MODE == c_MODE_DRAW);
  assign w_ly_visible = (LY < c_V_RES);
  assign w_col_full   = (r_col >= c_H_RES);
  assign w_col_inc    = r_col + 8'd1;
  // A pixel accepted in the mode-change cycle counts before deciding pad vs. end.
  assign w_col_after  = w_accept ? w_col_inc : r_col;

  always_comb begin
    w_px_shade = BGP[1:0];
    case (PX_OUT)
      2'd0:    w_px_shade = BGP[1:0];
      2'd1:    w_px_shade = BGP[3:2];
      2'd2:    w_px_shade = BGP[5:4];
      default: w_px_shade = BGP[7:6];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_FB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; LCD off overrides every state
  always_comb begin
    w_state_nxt = r_state;
    if (!LCD_EN) begin
      w_state_nxt = c_FB_IDLE;
    end else begin
      case (r_state)
        c_FB_IDLE: begin
          if (w_mode_draw && w_ly_visible) begin
            w_state_nxt = c_FB_DRAW;
          end
        end
        c_FB_DRAW: begin
          if (!w_mode_draw) begin
            w_state_nxt = (w_col_after < c_H_RES) ? c_FB_PAD : c_FB_LINE_END;
          end
        end
        c_FB_PAD: begin
          if (w_col_full || (w_col_inc >= c_H_RES)) begin
            w_state_nxt = c_FB_LINE_END;
          end
        end
        default: begin
          w_state_nxt = c_FB_IDLE;
        end
      endcase
    end
  end

  // Output / datapath control decode
  always_comb begin
    w_accept   = 1'b0;
    w_pad_step = 1'b0;
    w_start    = 1'b0;
    w_swap     = 1'b0;
    if (LCD_EN) begin
      case (r_state)
        c_FB_IDLE:     w_start    = w_mode_draw && w_ly_visible;
        c_FB_DRAW:     w_accept   = PX_valid && !w_col_full;
        c_FB_PAD:      w_pad_step = !w_col_full;
        default:       w_swap     = (r_row == c_LAST_ROW);
      endcase
    end
  end

  assign w_wr_en   = w_accept || w_pad_step;
  assign w_wr_data = w_accept ? w_px_shade : BGP[1:0];
  assign w_wr_addr = (ADDR_W'(r_row) * c_H_RES_A) + ADDR_W'(r_col);

  // Column/row tracking; the row is always reloaded from LY at line start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= 8'd0;
      r_row <= 8'd0;
    end else if (w_start) begin
      r_col <= 8'd0;
      r_row <= LY;
    end else if (w_wr_en) begin
      r_col <= w_col_inc;
    end
  end

  // One-cycle write pipeline and bank swap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= 2'd0;
      r_bank       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_we         <= w_wr_en;
      r_frame_done <= w_swap;
      if (w_wr_en) begin
        r_addr <= w_wr_addr;
        r_data <= w_wr_data;
      end
      if (w_swap) begin
        r_bank <= ~r_bank;
      end
    end
  end

  assign FB_WE      = r_we;
  assign FB_BANK    = r_bank;
  assign FB_ADDR    = r_addr;
  assign FB_DATA    = r_data;
  assign DISP_BANK  = ~r_bank;
  assign FRAME_DONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ppu_fb_writer.sv
`default_nettype none
// =============================================================================
// Module      : tb_ppu_fb_writer
// Description : Directed self-checking bench for ppu_fb_writer.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_ppu_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_en;
  logic [1:0]  ppu_mode;
  logic [7:0]  ly;
  logic [7:0]  bgp;
  logic [1:0]  px_out;
  logic        px_valid;
  logic        fb_we;
  logic        fb_bank;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        disp_bank;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ppu_fb_writer #(.H_RES(160), .V_RES(144), .ADDR_W(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .LCD_EN     (lcd_en),
    .PPU_MODE   (ppu_mode),
    .LY         (ly),
    .BGP        (bgp),
    .PX_OUT     (px_out),
    .PX_valid   (px_valid),
    .FB_WE      (fb_we),
    .FB_BANK    (fb_bank),
    .FB_ADDR    (fb_addr),
    .FB_DATA    (fb_data),
    .DISP_BANK  (disp_bank),
    .FRAME_DONE (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IDLE -> DRAW entry cycle; no pixel is presented in it
  task automatic start_line(input logic [7:0] line);
    lcd_en   = 1'b1;
    ly       = line;
    ppu_mode = 2'd3;
    px_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; lcd_en = 1'b0; ppu_mode = 2'd0; ly = 8'd0;
    bgp = 8'h00; px_out = 2'd0; px_valid = 1'b0;
    step(); step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", fb_we); end
    n_cmp++; if (fb_bank !== 1'b0) begin n_bad++; $display("FAIL reset_bank: got %b want 0", fb_bank); end
    n_cmp++; if (disp_bank !== 1'b1) begin n_bad++; $display("FAIL reset_disp: got %b want 1", disp_bank); end
    n_cmp++; if (fb_addr !== 15'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", fb_addr); end
    n_cmp++; if (fb_data !== 2'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", fb_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_cmp++; if (dut.r_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dut.r_state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_draw_line();
    bgp = 8'hE4;
    start_line(8'd5);
    for (int i = 0; i < 160; i++) begin
      px_valid = 1'b1;
      px_out   = 2'(i % 4);
      ppu_mode = (i == 159) ? 2'd0 : 2'd3;
      step();
      n_cmp++;
      if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'(800 + i), 2'(i % 4)}) begin
        n_bad++;
        $display("FAIL draw_px%0d: we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                 i, fb_we, fb_addr, fb_data, 800 + i, i % 4);
      end
    end
    px_valid = 1'b0;
    step();
    n_cmp++;
    if ({fb_we, frame_done} !== 2'b00) begin
      n_bad++; $display("FAIL draw_tail: we=%b fd=%b want 0 0", fb_we, frame_done);
    end
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL draw_nofd: got %b want 0", frame_done); end
  endtask

  task automatic test_overrun();
    int nwr = 0;
    bgp = 8'h1B;
    start_line(8'd0);
    for (int i = 0; i < 170; i++) begin
      px_valid = 1'b1; px_out = 2'd3; ppu_mode = 2'd3;
      step();
      if (fb_we === 1'b1) nwr++;
      if (i < 160) begin
        n_cmp++;
        if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'(i), 2'd0}) begin
          n_bad++;
          $display("FAIL ovr_px%0d: we=%b addr=%0d data=%0d want we=1 addr=%0d data=0",
                   i, fb_we, fb_addr, fb_data, i);
        end
      end else begin
        n_cmp++;
        if (fb_we !== 1'b0) begin n_bad++; $display("FAIL ovr_drop%0d: we=%b want 0", i, fb_we); end
      end
    end
    px_valid = 1'b0; ppu_mode = 2'd0;
    step();
    if (fb_we === 1'b1) nwr++;
    step();
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL ovr_fd: got %b want 0", frame_done); end
    step();
    n_cmp++; if (nwr != 160) begin n_bad++; $display("FAIL ovr_count: got %0d want 160", nwr); end
  endtask

  task automatic test_pad();
    bgp = 8'hE4;
    start_line(8'd10);
    for (int i = 0; i < 100; i++) begin
      px_valid = 1'b1; px_out = 2'(i % 4); ppu_mode = 2'd3;
      step();
      n_cmp++;
      if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'(1600 + i), 2'(i % 4)}) begin
        n_bad++;
        $display("FAIL padline_px%0d: we=%b addr=%0d data=%0d want addr=%0d", i, fb_we, fb_addr, fb_data, 1600 + i);
      end
    end
    px_valid = 1'b0; ppu_mode = 2'd0; bgp = 8'hE7;
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL pad_gap: we=%b want 0", fb_we); end
    for (int j = 0; j < 60; j++) begin
      step();
      n_cmp++;
      if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'(1700 + j), 2'd3}) begin
        n_bad++;
        $display("FAIL pad_w%0d: we=%b addr=%0d data=%0d want we=1 addr=%0d data=3", j, fb_we, fb_addr, fb_data, 1700 + j);
      end
    end
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL pad_end: we=%b want 0", fb_we); end
    step();
  endtask

  task automatic test_full_frame(input logic exp_bank);
    int   fd_seen = 0;
    logic exp_fd;
    bgp = 8'hE4;
    for (int l = 0; l < 144; l++) begin
      start_line(8'(l));
      if (frame_done === 1'b1) fd_seen++;
      ppu_mode = 2'd0; px_valid = 1'b1; px_out = 2'(l % 4);
      step();
      px_valid = 1'b0;
      if (frame_done === 1'b1) fd_seen++;
      for (int j = 1; j < 160; j++) begin
        step();
        if (frame_done === 1'b1) fd_seen++;
      end
      n_cmp++;
      if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'(l * 160 + 159), 2'd0}) begin
        n_bad++;
        $display("FAIL frame_last_l%0d: we=%b addr=%0d data=%0d want we=1 addr=%0d data=0",
                 l, fb_we, fb_addr, fb_data, l * 160 + 159);
      end
      step();
      exp_fd = (l == 143);
      n_cmp++;
      if (frame_done !== exp_fd) begin
        n_bad++; $display("FAIL frame_fd_l%0d: got %b want %b", l, frame_done, exp_fd);
      end
      if (frame_done === 1'b1) fd_seen++;
      step();
      if (frame_done === 1'b1) fd_seen++;
    end
    n_cmp++; if (fd_seen != 1) begin n_bad++; $display("FAIL frame_pulses: got %0d want 1", fd_seen); end
    n_cmp++; if (fb_bank !== exp_bank) begin n_bad++; $display("FAIL frame_bank: got %b want %b", fb_bank, exp_bank); end
    n_cmp++; if (disp_bank !== ~exp_bank) begin n_bad++; $display("FAIL frame_disp: got %b want %b", disp_bank, ~exp_bank); end
  endtask

  task automatic test_lcd_abort();
    int nwr = 0;
    int nfd = 0;
    bgp = 8'hE4;
    start_line(8'd143);
    for (int i = 0; i < 40; i++) begin
      px_valid = 1'b1; px_out = 2'(i % 4); ppu_mode = 2'd3;
      step();
    end
    n_cmp++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'd22919, 2'd3}) begin
      n_bad++; $display("FAIL abort_px40: we=%b addr=%0d data=%0d want we=1 addr=22919 data=3", fb_we, fb_addr, fb_data);
    end
    lcd_en = 1'b0;
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL abort_cut: we=%b want 0", fb_we); end
    for (int k = 0; k < 160; k++) begin
      ppu_mode = (k < 150) ? 2'd3 : 2'd0;
      step();
      if (fb_we === 1'b1) nwr++;
      if (frame_done === 1'b1) nfd++;
    end
    n_cmp++; if (nwr != 0) begin n_bad++; $display("FAIL abort_writes: got %0d want 0", nwr); end
    n_cmp++; if (nfd != 0) begin n_bad++; $display("FAIL abort_fd: got %0d want 0", nfd); end
    n_cmp++; if (fb_bank !== 1'b0) begin n_bad++; $display("FAIL abort_bank: got %b want 0", fb_bank); end
    n_cmp++; if (dut.r_state !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", dut.r_state); end
    px_valid = 1'b0; lcd_en = 1'b1;
    step();
  endtask

  task automatic test_reset_midline();
    int nwr = 0;
    bgp = 8'hE4;
    start_line(8'd143);
    ppu_mode = 2'd0; px_valid = 1'b1; px_out = 2'd0;
    step();
    px_valid = 1'b0;
    for (int j = 1; j < 160; j++) step();
    step(); step();
    n_cmp++; if (fb_bank !== 1'b1) begin n_bad++; $display("FAIL rstml_pre_bank: got %b want 1", fb_bank); end
    start_line(8'd20);
    for (int i = 0; i < 30; i++) begin
      px_valid = 1'b1; px_out = 2'(i % 4);
      step();
    end
    rst = 1'b1;
    step();
    n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL rstml_we: got %b want 0", fb_we); end
    n_cmp++; if (fb_bank !== 1'b0) begin n_bad++; $display("FAIL rstml_bank: got %b want 0", fb_bank); end
    n_cmp++; if (disp_bank !== 1'b1) begin n_bad++; $display("FAIL rstml_disp: got %b want 1", disp_bank); end
    n_cmp++; if (fb_addr !== 15'd0) begin n_bad++; $display("FAIL rstml_addr: got %0d want 0", fb_addr); end
    n_cmp++; if (fb_data !== 2'd0) begin n_bad++; $display("FAIL rstml_data: got %0d want 0", fb_data); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rstml_fd: got %b want 0", frame_done); end
    rst = 1'b0; px_valid = 1'b0; ppu_mode = 2'd0;
    step();
    ly = 8'd200; ppu_mode = 2'd3;
    for (int k = 0; k < 175; k++) begin
      px_valid = (k < 170);
      if (k == 170) ppu_mode = 2'd0;
      step();
      if (fb_we === 1'b1) nwr++;
    end
    n_cmp++; if (nwr != 0) begin n_bad++; $display("FAIL ly200_writes: got %0d want 0", nwr); end
  endtask

  initial begin
    test_reset();
    test_draw_line();
    test_overrun();
    test_pad();
    test_full_frame(1'b1);
    test_full_frame(1'b0);
    test_lcd_abort();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
